// File: rtl/alu_branch_unit_pkg.sv
// alu_branch_unit_pkg: ALU op codes, instruction field constants and control encodings
package alu_branch_unit_pkg;
   localparam logic [5:0] ALU_ADD  = 6'd0;
   localparam logic [5:0] ALU_ADDU = 6'd1;
   localparam logic [5:0] ALU_SUB  = 6'd2;
   localparam logic [5:0] ALU_SUBU = 6'd3;
   localparam logic [5:0] ALU_AND  = 6'd4;
   localparam logic [5:0] ALU_OR   = 6'd5;
   localparam logic [5:0] ALU_XOR  = 6'd6;
   localparam logic [5:0] ALU_NOR  = 6'd7;
   localparam logic [5:0] ALU_SLT  = 6'd8;
   localparam logic [5:0] ALU_SLTU = 6'd9;
   localparam logic [5:0] ALU_SLL  = 6'd10;
   localparam logic [5:0] ALU_SRL  = 6'd11;
   localparam logic [5:0] ALU_SRA  = 6'd12;
   localparam logic [5:0] ALU_SLLV = 6'd13;
   localparam logic [5:0] ALU_SRLV = 6'd14;
   localparam logic [5:0] ALU_SRAV = 6'd15;
   localparam logic [5:0] ALU_LUI  = 6'd16;
   localparam logic [5:0] ALU_NOP  = 6'd63;

   localparam logic [1:0] CTRL_ADD  = 2'b00;
   localparam logic [1:0] CTRL_SUB  = 2'b01;
   localparam logic [1:0] CTRL_RTYP = 2'b10;
   localparam logic [1:0] CTRL_ITYP = 2'b11;

   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
endpackage

// File: rtl/alu_branch_unit_alu_core.sv
// alu_core: 32-bit combinational ALU datapath with signed overflow flag
module alu_core
   import alu_branch_unit_pkg::*;
(
   input  logic [5:0]  alu_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        overflow
);
   logic [31:0] sum, diff;
   assign sum  = a + b;
   assign diff = a - b;
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_op)
         ALU_ADD:  begin
            result   = sum;
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         ALU_ADDU: result = sum;
         ALU_SUB:  begin
            result   = diff;
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         ALU_SUBU: result = diff;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
         ALU_SLLV: result = b << a[4:0];
         ALU_SRLV: result = b >> a[4:0];
         ALU_SRAV: result = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI:  result = {b[15:0], 16'h0000};
         default:  result = '0;
      endcase
   end
endmodule

// File: rtl/alu_branch_unit.sv
// alu_branch_unit: ALU control decode, datapath, branch compare and registered result
module alu_branch_unit
   import alu_branch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] cmp_b,
   input  logic [1:0]  alu_ctrl_op,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [4:0]  branch_funct,
   output logic [5:0]  alu_op,
   output logic [31:0] alu_result,
   output logic [31:0] alu_result_q,
   output logic        zero,
   output logic        overflow,
   output logic        branch_succeed
);
   logic [5:0]  funct_op, opcode_op;
   logic [31:0] alu_result_d;
   always_comb begin
      funct_op = ALU_NOP;
      case (funct)
         F_ADD:  funct_op = ALU_ADD;
         F_ADDU: funct_op = ALU_ADDU;
         F_SUB:  funct_op = ALU_SUB;
         F_SUBU: funct_op = ALU_SUBU;
         F_AND:  funct_op = ALU_AND;
         F_OR:   funct_op = ALU_OR;
         F_XOR:  funct_op = ALU_XOR;
         F_NOR:  funct_op = ALU_NOR;
         F_SLT:  funct_op = ALU_SLT;
         F_SLTU: funct_op = ALU_SLTU;
         F_SLL:  funct_op = ALU_SLL;
         F_SRL:  funct_op = ALU_SRL;
         F_SRA:  funct_op = ALU_SRA;
         F_SLLV: funct_op = ALU_SLLV;
         F_SRLV: funct_op = ALU_SRLV;
         F_SRAV: funct_op = ALU_SRAV;
         default: funct_op = ALU_NOP;
      endcase
   end
   always_comb begin
      opcode_op = ALU_NOP;
      case (opcode)
         OP_ADDI, OP_ADDIU: opcode_op = ALU_ADD;
         OP_ANDI:  opcode_op = ALU_AND;
         OP_ORI:   opcode_op = ALU_OR;
         OP_XORI:  opcode_op = ALU_XOR;
         OP_SLTI:  opcode_op = ALU_SLT;
         OP_SLTIU: opcode_op = ALU_SLTU;
         OP_LUI:   opcode_op = ALU_LUI;
         default:  opcode_op = ALU_NOP;
      endcase
   end
   always_comb
      alu_op = alu_ctrl_op == CTRL_ADD  ? ALU_ADD :
               alu_ctrl_op == CTRL_SUB  ? ALU_SUB :
               alu_ctrl_op == CTRL_RTYP ? funct_op : opcode_op;
   alu_core u_alu_core (
      .alu_op   (alu_op),
      .a        (src_a),
      .b        (src_b),
      .shamt    (shamt),
      .result   (alu_result),
      .overflow (overflow)
   );
   assign zero = alu_result == 32'h0;
   // REGIMM: bit 4 of branch_funct is the link variant, which compares identically
   always_comb begin
      branch_succeed = 1'b0;
      case (opcode)
         OP_BEQ:    branch_succeed = src_a == cmp_b;
         OP_BNE:    branch_succeed = src_a != cmp_b;
         OP_BLEZ:   branch_succeed = src_a[31] || src_a == 32'h0;
         OP_BGTZ:   branch_succeed = !src_a[31] && src_a != 32'h0;
         OP_REGIMM: branch_succeed = branch_funct[3:1] == 3'b000 && (branch_funct[0] ^ src_a[31]);
         default:   branch_succeed = 1'b0;
      endcase
   end
   always_comb alu_result_d = rst ? 32'h0 : alu_result;
   always_ff @(posedge clk) alu_result_q <= alu_result_d;
endmodule

// File: tb/tb_alu_branch_unit.sv
// tb_alu_branch_unit: directed-vector self-checking bench for alu_branch_unit
module tb_alu_branch_unit;
   import alu_branch_unit_pkg::*;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src_a, src_b, cmp_b;
   logic [1:0]  alu_ctrl_op;
   logic [5:0]  opcode, funct;
   logic [4:0]  shamt, branch_funct;
   logic [5:0]  alu_op;
   logic [31:0] alu_result, alu_result_q;
   logic        zero, overflow, branch_succeed;
   int          n_cmp = 0;
   int          n_bad = 0;

   alu_branch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .src_a          (src_a),
      .src_b          (src_b),
      .cmp_b          (cmp_b),
      .alu_ctrl_op    (alu_ctrl_op),
      .opcode         (opcode),
      .funct          (funct),
      .shamt          (shamt),
      .branch_funct   (branch_funct),
      .alu_op         (alu_op),
      .alu_result     (alu_result),
      .alu_result_q   (alu_result_q),
      .zero           (zero),
      .overflow       (overflow),
      .branch_succeed (branch_succeed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic alu(input logic [1:0] c, input logic [5:0] op, input logic [5:0] f,
                      input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
      alu_ctrl_op = c; opcode = op; funct = f; shamt = sh; src_a = a; src_b = b;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cmp_b = '0; branch_funct = '0;
      alu(2'b10, 6'h00, 6'h20, 5'd0, 32'h0, 32'h0);
      tick;
      chk("reset_q", alu_result_q, 32'h0);
      rst = 1'b0;

      alu(2'b10, 6'h00, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h1);
      chk("add_res", alu_result, 32'h80000000);
      chk("add_ovf", overflow, 1);
      chk("add_zero", zero, 0);
      chk("add_op", alu_op, ALU_ADD);
      tick;
      chk("add_q", alu_result_q, 32'h80000000);

      alu(2'b10, 6'h00, 6'h21, 5'd0, 32'h7FFFFFFF, 32'h1);
      chk("addu_ovf", overflow, 0);
      alu(2'b10, 6'h00, 6'h22, 5'd0, 32'h80000000, 32'h1);
      chk("sub_res", alu_result, 32'h7FFFFFFF);
      chk("sub_ovf", overflow, 1);
      alu(2'b10, 6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1);
      chk("slt", alu_result, 32'h1);
      alu(2'b10, 6'h00, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1);
      chk("sltu", alu_result, 32'h0);
      alu(2'b10, 6'h00, 6'h03, 5'd4, 32'h0, 32'hF0000000);
      chk("sra", alu_result, 32'hFF000000);
      alu(2'b10, 6'h00, 6'h02, 5'd4, 32'h0, 32'hF0000000);
      chk("srl", alu_result, 32'h0F000000);
      alu(2'b10, 6'h00, 6'h06, 5'd0, 32'd24, 32'h80000000);
      chk("srlv", alu_result, 32'h00000080);
      alu(2'b10, 6'h00, 6'h07, 5'd0, 32'd24, 32'h80000000);
      chk("srav", alu_result, 32'hFFFFFF80);
      alu(2'b10, 6'h00, 6'h04, 5'd0, 32'd8, 32'h000000FF);
      chk("sllv", alu_result, 32'h0000FF00);
      alu(2'b10, 6'h00, 6'h00, 5'd0, 32'h0, 32'hA5A5A5A5);
      chk("sll0", alu_result, 32'hA5A5A5A5);
      alu(2'b10, 6'h00, 6'h27, 5'd0, 32'h0F0F0000, 32'h000000F0);
      chk("nor", alu_result, 32'hF0F0FF0F);
      alu(2'b10, 6'h00, 6'h26, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
      chk("xor", alu_result, 32'hF0F0F0F0);
      alu(2'b11, 6'h0F, 6'h00, 5'd0, 32'h0, 32'h00001234);
      chk("lui", alu_result, 32'h12340000);
      alu(2'b11, 6'h0D, 6'h00, 5'd0, 32'h00F0, 32'h000F);
      chk("ori", alu_result, 32'h000000FF);
      alu(2'b11, 6'h3F, 6'h00, 5'd0, 32'h5, 32'h5);
      chk("iop_nop", alu_result, 32'h0);
      alu(2'b10, 6'h00, 6'h3F, 5'd0, 32'h5, 32'h5);
      chk("nop_res", alu_result, 32'h0);
      chk("nop_zero", zero, 1);
      chk("nop_op", alu_op, ALU_NOP);
      alu(2'b00, 6'h00, 6'h3F, 5'd0, 32'd3, 32'd4);
      chk("ctrl_add", alu_result, 32'd7);
      alu(2'b01, 6'h00, 6'h3F, 5'd0, 32'd3, 32'd4);
      chk("ctrl_sub", alu_result, 32'hFFFFFFFF);
      chk("ctrl_sub_ovf", overflow, 0);

      cmp_b = 32'd5;
      alu(2'b00, 6'h04, 6'h00, 5'd0, 32'd5, 32'h0);
      chk("beq_t", branch_succeed, 1);
      alu(2'b10, 6'h05, 6'h00, 5'd0, 32'd5, 32'h0);
      chk("bne_f", branch_succeed, 0);
      cmp_b = 32'd6;
      alu(2'b11, 6'h05, 6'h00, 5'd0, 32'd5, 32'h0);
      chk("bne_t", branch_succeed, 1);
      branch_funct = 5'h01;
      alu(2'b00, 6'h01, 6'h00, 5'd0, 32'h80000000, 32'h0);
      chk("bgez_f", branch_succeed, 0);
      branch_funct = 5'h10;
      alu(2'b00, 6'h01, 6'h00, 5'd0, 32'h80000000, 32'h0);
      chk("bltzal_t", branch_succeed, 1);
      branch_funct = 5'h02;
      alu(2'b00, 6'h01, 6'h00, 5'd0, 32'h80000000, 32'h0);
      chk("regimm_other", branch_succeed, 0);
      alu(2'b00, 6'h07, 6'h00, 5'd0, 32'h0, 32'h0);
      chk("bgtz_zero", branch_succeed, 0);
      alu(2'b00, 6'h06, 6'h00, 5'd0, 32'h0, 32'h0);
      chk("blez_zero", branch_succeed, 1);
      alu(2'b00, 6'h08, 6'h00, 5'd0, 32'h0, 32'h0);
      chk("no_branch", branch_succeed, 0);

      alu(2'b00, 6'h00, 6'h00, 5'd0, 32'h1234, 32'h0);
      tick;
      chk("load_q", alu_result_q, 32'h1234);
      rst = 1'b1;
      tick;
      chk("mid_rst_q", alu_result_q, 32'h0);
      chk("rst_comb", alu_result, 32'h1234);
      rst = 1'b0;
      alu(2'b00, 6'h00, 6'h00, 5'd0, 32'h55, 32'h0);
      tick;
      chk("resume_q", alu_result_q, 32'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
